mult_div_unit: RTL
==================

# mult_div_unit

Iterative 32-bit unsigned multiply/divide unit with HI/LO result registers for the MIPS datapath. It sits beside the combinational ALU and executes the multi-cycle MULTU/DIVU operations that the ALU does not implement. It produces 64-bit products and 32-bit quotient/remainder pairs over 32 cycles, using a start/busy/done handshake. It also supports direct MTHI/MTLO writes of HI and LO.

## Interface
Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start_i  input  1  request to begin the operation selected by op_i; sampled on the rising edge.
- op_i  input  2  operation select: 2'b00 MULTU, 2'b01 DIVU; 2'b10 and 2'b11 are reserved.
- a_i  input  WIDTH  operand A (multiplicand or dividend); also the write data for mthi_i/mtlo_i.
- b_i  input  WIDTH  operand B (multiplier or divisor).
- mthi_i  input  1  write a_i into HI.
- mtlo_i  input  1  write a_i into LO.
- hi_o  output  WIDTH  HI register: upper product word or remainder.
- lo_o  output  WIDTH  LO register: lower product word or quotient.
- busy_o  output  1  high while an operation is iterating.
- done_o  output  1  one-cycle pulse when a result is committed to HI/LO.

## Operation
- States: IDLE, MUL, DIV, DONE.
  - busy_o = 1 only in MUL and DIV.
  - done_o = 1 only in DONE.
- Accept condition: start_i = 1 with a legal op_i, while in IDLE or DONE.
  - Operands are captured into internal working registers on the accepting edge.
  - The iteration counter is cleared to 0.
  - MULTU goes to MUL; DIVU goes to DIV.
- start_i is ignored when op_i is reserved and while busy_o = 1; operands presented in those cycles are never captured.
- MUL iteration: shift-add, one multiplier bit per cycle, LSB first, on a 2·WIDTH accumulator.
  - Result: {HI, LO} = a × b, unsigned, exact 64-bit value.
- DIV iteration: restoring division, one quotient bit per cycle, MSB first.
  - Result: LO = a / b, HI = a % b, unsigned.
- Divide by zero (b_i = 0 at acceptance): go directly to DONE on the next edge with HI = a_i, LO = all ones. No iteration is performed.
- HI/LO hold their previous values throughout MUL/DIV and are written only on the edge entering DONE.
- DONE lasts exactly one cycle, then returns to IDLE unless a new operation is accepted on that edge.
- mthi_i/mtlo_i:
  - Honoured only in IDLE or DONE, when start_i is not also accepted on that edge.
  - Write a_i into HI and/or LO on that edge. Both may be asserted together.
  - No done_o pulse is generated.
  - Ignored while busy_o = 1.
- Simultaneous accepted start_i and mthi_i/mtlo_i: the start wins and the moves are dropped.

## Timing
- Reset (reset = 0 at a rising edge): state = IDLE, hi_o = 0, lo_o = 0, busy_o = 0, done_o = 0, counter = 0.
  - Applies regardless of state.
  - An in-flight operation is abandoned: no done_o pulse and no HI/LO update.
- Let E0 be the edge on which start is accepted.
  - busy_o rises after E0.
  - Iterations occur on edges E1..E32.
  - E32 commits HI/LO and enters DONE; done_o is high for the cycle after E32.
  - Latency from accepting edge to done_o is 33 cycles.
  - busy_o is high for exactly 32 cycles.
- Divide by zero: E1 enters DONE; done_o is high for the cycle after E1, and busy_o is high for one cycle.
- Back-to-back operation: a start accepted on the edge leaving DONE re-enters MUL/DIV with no IDLE cycle.
- mthi_i/mtlo_i results are visible on hi_o/lo_o in the cycle after the write edge.
- Arithmetic is purely unsigned with no overflow: the product always fits in 64 bits and the remainder is always less than b.

## Test plan
- Reset then MULTU: a = 0xFFFF_FFFF, b = 0xFFFF_FFFF -> done_o high exactly 33 cycles after acceptance; hi_o = 0xFFFF_FFFE, lo_o = 0x0000_0001; busy_o high for 32 cycles.
- DIVU: a = 100, b = 7 -> lo_o = 14, hi_o = 2. Then DIVU with a = 5, b = 0 -> done_o one cycle after acceptance; hi_o = 5, lo_o = 0xFFFF_FFFF.
- start_i pulsed mid-MULTU (a = 3, b = 4) with different operands -> second start ignored; result hi_o = 0, lo_o = 12; exactly one done_o pulse.
- mthi_i with a_i = 0x1234_5678 in IDLE -> hi_o = 0x1234_5678 next cycle, lo_o unchanged, no done_o. mtlo_i during busy -> ignored.
- Reset asserted on iteration 16 of a DIVU -> all outputs 0 on the next cycle; no done_o pulse; a following MULTU of 6 × 7 gives lo_o = 42.
- Back-to-back: MULTU 2 × 3, then DIVU 9 / 2 accepted in the DONE cycle -> lo_o = 6 at the first done_o; lo_o = 4, hi_o = 1 exactly 33 cycles later.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   dvsr;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quot_nxt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               dz;
    logic               open;
    logic               accept;
    logic               last;
    logic               busy;
    logic               done;

    assign open   = (state == IDLE) || (state == DONE);
    assign accept = open && start_i && !op_i[1];
    assign last   = (cnt == CW'(WIDTH - 1));

    // Multiply step: add the shifted multiplicand when the multiplier LSB is set.
    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    // Restoring divide step: keep the trial difference only if it is non-negative.
    assign shifted  = {rem, quot[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvsr};
    assign rem_nxt  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_nxt = {quot[WIDTH-2:0], ~diff[WIDTH]};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = op_i[0] ? DIV : MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (dz || last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
                if (accept) begin
                    state_nxt = op_i[0] ? DIV : MUL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            quot   <= '0;
            dvsr   <= '0;
            rem    <= '0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_i};
            mplier <= b_i;
            quot   <= a_i;
            dvsr   <= b_i;
            rem    <= '0;
            dz     <= op_i[0] && (b_i == '0);
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) begin
                {hi, lo} <= acc_nxt;
            end
        end else if (state == DIV) begin
            if (dz) begin
                hi <= quot;
                lo <= '1;
            end else begin
                rem  <= rem_nxt;
                quot <= quot_nxt;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    hi <= rem_nxt;
                    lo <= quot_nxt;
                end
            end
        end else if (open) begin
            if (mthi_i) begin
                hi <= a_i;
            end
            if (mtlo_i) begin
                lo <= a_i;
            end
        end
    end

    assign hi_o   = hi;
    assign lo_o   = lo;
    assign busy_o = busy;
    assign done_o = done;

endmodule
